// File: rtl/mem_addr_if.sv
// Address-event bus between the memory controller (master) and the occupancy tracker (slave).
interface mem_addr_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              used_valid;
  logic [ADDR_W-1:0] used_address;
  logic              read_or_write;
  logic              freed;
  logic [ADDR_W-1:0] freed_address;
  logic [ADDR_W-1:0] free_addr;
  logic              free_valid;
  logic [ADDR_W:0]   used_count;
  logic              full;
  logic              empty;
  logic              double_free;
  logic              read_miss;

  modport master (
    output used_valid, used_address, read_or_write, freed, freed_address,
    input  free_addr, free_valid, used_count, full, empty, double_free, read_miss
  );

  modport slave (
    input  used_valid, used_address, read_or_write, freed, freed_address,
    output free_addr, free_valid, used_count, full, empty, double_free, read_miss
  );
endinterface

// File: rtl/mem_addr_tracker.sv
// Per-address occupancy bitmap with use/free event handling, error pulses and a
// background scanner that keeps offering a free address for allocation.
module mem_addr_tracker #(
  parameter int unsigned ADDR_W = 9,
  parameter logic        WRITE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  mem_addr_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {SCAN, HOLD} scan_state_t;

  scan_state_t       state;
  logic [DEPTH-1:0]  bitmap;
  logic [DEPTH-1:0]  nb;
  logic [DEPTH-1:0]  w_vec;
  logic [DEPTH-1:0]  f_vec;
  logic [ADDR_W-1:0] scan_ptr;
  logic [ADDR_W-1:0] free_addr_q;
  logic              free_valid_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              empty_q;
  logic              double_free_q;
  logic              read_miss_q;
  logic              wr;
  logic              rd;
  logic              same_addr;
  logic              w_set;
  logic              f_clr;

  // A write and free to the same address in one cycle nets to a cleared bit;
  // the free is then counted as consuming the write rather than as a double free.
  always_comb begin
    wr         = bus.used_valid && (bus.read_or_write == WRITE);
    rd         = bus.used_valid && (bus.read_or_write != WRITE);
    w_vec      = '0;
    f_vec      = '0;
    if (wr)        w_vec[bus.used_address]  = 1'b1;
    if (bus.freed) f_vec[bus.freed_address] = 1'b1;
    nb         = (bitmap | w_vec) & ~f_vec;
    same_addr  = wr && bus.freed && (bus.used_address == bus.freed_address);
    w_set      = wr && !bitmap[bus.used_address];
    f_clr      = bus.freed && (bitmap[bus.freed_address] || same_addr);
    count_next = count_q + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, f_clr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap        <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      double_free_q <= 1'b0;
      read_miss_q   <= 1'b0;
    end else begin
      bitmap        <= nb;
      count_q       <= count_next;
      full_q        <= (count_next == (ADDR_W+1)'(DEPTH));
      empty_q       <= (count_next == '0);
      double_free_q <= bus.freed && !bitmap[bus.freed_address] && !same_addr;
      read_miss_q   <= rd && !bitmap[bus.used_address];
    end
  end

  // Scanner looks at next-state occupancy so an address written this cycle is never offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SCAN;
      scan_ptr     <= '0;
      free_addr_q  <= '0;
      free_valid_q <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (!nb[scan_ptr]) begin
            free_addr_q  <= scan_ptr;
            free_valid_q <= 1'b1;
            state        <= HOLD;
          end else begin
            scan_ptr <= scan_ptr + 1'b1;
          end
        end
        HOLD: begin
          if (nb[free_addr_q]) begin
            free_valid_q <= 1'b0;
            scan_ptr     <= free_addr_q + 1'b1;
            state        <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.free_addr   = free_addr_q;
  assign bus.free_valid  = free_valid_q;
  assign bus.used_count  = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.double_free = double_free_q;
  assign bus.read_miss   = read_miss_q;
endmodule

// File: tb/tb_mem_addr_tracker.sv
// Directed bench for mem_addr_tracker: event rules, error pulses, scanner and reset.
module tb_mem_addr_tracker;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_addr_if #(.ADDR_W(ADDR_W)) bus ();

  mem_addr_tracker #(.ADDR_W(ADDR_W), .WRITE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic uv, input int unsigned ua, input logic rw,
                       input logic fr, input int unsigned fa);
    bus.used_valid    = uv;
    bus.used_address  = ADDR_W'(ua);
    bus.read_or_write = rw;
    bus.freed         = fr;
    bus.freed_address = ADDR_W'(fa);
  endtask

  task automatic clear();
    drive(1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_free_valid"}, bus.free_valid, 0);
    check_eq({tag, "_free_addr"}, bus.free_addr, 0);
    check_eq({tag, "_count"}, bus.used_count, 0);
    check_eq({tag, "_empty"}, bus.empty, 1);
    check_eq({tag, "_full"}, bus.full, 0);
    check_eq({tag, "_double_free"}, bus.double_free, 0);
    check_eq({tag, "_read_miss"}, bus.read_miss, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    clear();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");

    rst = 1'b0;
    tick();
    check_eq("post_reset_free_valid", bus.free_valid, 1);
    check_eq("post_reset_free_addr", bus.free_addr, 0);
    tick();
    check_eq("idle_free_valid", bus.free_valid, 1);
    check_eq("idle_empty", bus.empty, 1);

    // Writes 0,1,2 back to back
    drive(1'b1, 0, 1'b1, 1'b0, 0); tick();
    check_eq("wr0_count", bus.used_count, 1);
    check_eq("wr0_free_valid", bus.free_valid, 0);
    check_eq("wr0_empty", bus.empty, 0);
    drive(1'b1, 1, 1'b1, 1'b0, 0); tick();
    check_eq("wr1_count", bus.used_count, 2);
    check_eq("wr1_free_valid", bus.free_valid, 0);
    drive(1'b1, 2, 1'b1, 1'b0, 0); tick();
    check_eq("wr2_count", bus.used_count, 3);
    clear(); tick();
    check_eq("settle_free_valid", bus.free_valid, 1);
    check_eq("settle_free_addr", bus.free_addr, 3);

    // Rewrite of a used address changes nothing
    drive(1'b1, 1, 1'b1, 1'b0, 0); tick();
    check_eq("rewrite_count", bus.used_count, 3);

    // Double free and read miss pulses
    drive(1'b0, 0, 1'b0, 1'b1, 5); tick();
    check_eq("dfree_pulse", bus.double_free, 1);
    check_eq("dfree_count", bus.used_count, 3);
    clear(); tick();
    check_eq("dfree_end", bus.double_free, 0);
    drive(1'b1, 7, 1'b0, 1'b0, 0); tick();
    check_eq("rmiss_pulse", bus.read_miss, 1);
    clear(); tick();
    check_eq("rmiss_end", bus.read_miss, 0);
    drive(1'b1, 1, 1'b0, 1'b0, 0); tick();
    check_eq("read_hit_no_miss", bus.read_miss, 0);

    // Same-cycle write and free of address 9, first unused then used
    drive(1'b1, 9, 1'b1, 1'b1, 9); tick();
    check_eq("wf9_new_count", bus.used_count, 3);
    check_eq("wf9_new_dfree", bus.double_free, 0);
    drive(1'b1, 9, 1'b0, 1'b0, 0); tick();
    check_eq("wf9_new_bit_clear", bus.read_miss, 1);
    drive(1'b1, 9, 1'b1, 1'b0, 0); tick();
    check_eq("wr9_count", bus.used_count, 4);
    drive(1'b1, 9, 1'b1, 1'b1, 9); tick();
    check_eq("wf9_used_count", bus.used_count, 3);
    check_eq("wf9_used_dfree", bus.double_free, 0);
    drive(1'b1, 9, 1'b0, 1'b0, 0); tick();
    check_eq("wf9_used_bit_clear", bus.read_miss, 1);

    // Write and free to different addresses: count net zero
    drive(1'b1, 20, 1'b1, 1'b1, 2); tick();
    check_eq("wf_diff_count", bus.used_count, 3);
    check_eq("wf_diff_dfree", bus.double_free, 0);

    // Fill the whole space
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, 1'b1, 1'b0, 0);
      tick();
    end
    clear();
    check_eq("fill_count", bus.used_count, DEPTH);
    check_eq("fill_full", bus.full, 1);
    check_eq("fill_empty", bus.empty, 0);
    check_eq("fill_free_valid", bus.free_valid, 0);
    tick(); tick(); tick();
    check_eq("full_idle_free_valid", bus.free_valid, 0);

    // Open one hole and wait for the scanner to find it
    drive(1'b0, 0, 1'b0, 1'b1, 300); tick();
    clear();
    check_eq("hole_full", bus.full, 0);
    check_eq("hole_count", bus.used_count, DEPTH - 1);
    found = 1'b0;
    for (int c = 0; c < DEPTH + 8 && !found; c++) begin
      if (bus.free_valid) found = 1'b1;
      else tick();
    end
    check_eq("hole_found", found, 1);
    check_eq("hole_free_addr", bus.free_addr, 300);

    // Reset while holding an offer, with a write presented in the same cycle
    rst = 1'b1;
    drive(1'b1, 300, 1'b1, 1'b0, 0);
    tick();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    clear();
    tick();
    check_eq("rerun_free_valid", bus.free_valid, 1);
    check_eq("rerun_free_addr", bus.free_addr, 0);
    check_eq("rerun_count", bus.used_count, 0);
    drive(1'b1, 300, 1'b0, 1'b0, 0); tick();
    check_eq("reset_write_ignored", bus.read_miss, 1);
    clear();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
